// File: rtl/alu_pkg.sv
// Control codes and FSM state encoding for the EX-stage ALU.
// The decode-side control logic imports the same package.
package alu_pkg;

  localparam logic [2:0] ALU_ADDI = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_ADD  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative shift-add multiplier datapath; one multiplier bit per step.
// Defining MULTICYCLE_ALU_EARLY_EXIT_EN flags the last step once the remaining multiplier is zero.
module shift_add_mul #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] mcand_i,
  input  logic [DATA_W-1:0] mplier_i,
  output logic [DATA_W-1:0] acc_next_o,
  output logic              last_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign acc_next_o = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MULTICYCLE_ALU_EARLY_EXIT_EN
  // The post-shift multiplier is zero when no set bits remain above bit 0.
  assign last_o = (cnt_q == CNT_W'(DATA_W - 1)) || ((mplier_q >> 1) == '0);
`else
  assign last_o = (cnt_q == CNT_W'(DATA_W - 1));
`endif

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      acc_d    = '0;
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_next_o;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// EX-stage ALU: single-cycle add/sub/and/or, iterative mul, valid/ready on both sides.
// Optional MULTICYCLE_ALU_EARLY_EXIT_EN shortens mul to the highest set bit of B.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        ctrl_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              mul_start, mul_step, mul_last;
  logic [DATA_W-1:0] mul_acc_next;
  logic              accept;

  // Illegal codes fall through to zero so they still complete like any other op.
  function automatic logic [DATA_W-1:0] single_op(input logic [2:0] ctrl,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    case (ctrl)
      ALU_ADD, ALU_ADDI: single_op = a + b;
      ALU_SUB:           single_op = a + ~b + 1'b1;
      ALU_AND:           single_op = a & b;
      ALU_OR:            single_op = a | b;
      default:           single_op = '0;
    endcase
  endfunction

  shift_add_mul #(.DATA_W(DATA_W)) u_mul (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (mul_start),
    .step_i     (mul_step),
    .mcand_i    (src_a_i),
    .mplier_i   (src_b_i),
    .acc_next_o (mul_acc_next),
    .last_o     (mul_last)
  );

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q == MUL);
  assign result_o = result_q;
  assign zero_o   = (result_q == '0);
  assign accept   = valid_i && ready_o;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    mul_start = 1'b0;
    mul_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ctrl_i == ALU_MUL) begin
`ifdef MULTICYCLE_ALU_EARLY_EXIT_EN
            if (src_b_i == '0) begin
              result_d = '0;
              state_d  = DONE;
            end else begin
              mul_start = 1'b1;
              state_d   = MUL;
            end
`else
            mul_start = 1'b1;
            state_d   = MUL;
`endif
          end else begin
            result_d = single_op(ctrl_i, src_a_i, src_b_i);
            state_d  = DONE;
          end
        end
      end
      MUL: begin
        mul_step = 1'b1;
        if (mul_last) begin
          result_d = mul_acc_next;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu; expectations follow MULTICYCLE_ALU_EARLY_EXIT_EN.
module tb_multicycle_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  ctrl_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

`ifdef MULTICYCLE_ALU_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  multicycle_alu #(.DATA_W(32)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ctrl_i   (ctrl_i),
    .src_a_i  (src_a_i),
    .src_b_i  (src_b_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .zero_o   (zero_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request for exactly one rising edge, returning at the negedge after it.
  task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_i = 1'b1;
    ctrl_i  = ctrl;
    src_a_i = a;
    src_b_i = b;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Latency 1 means valid_o is already high at the first negedge after the accept edge.
  task automatic waitValid(output int lat, output int busyCycles);
    lat = 1;
    busyCycles = 0;
    while (!valid_o && lat < 100) begin
      if (busy_o) busyCycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOp(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expRes,
                       input logic expZero, input int expLat);
    int lat, busyCycles;
    applyStimulus(ctrl, a, b);
    waitValid(lat, busyCycles);
    checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_res"}, result_o, expRes);
    checkOutput({tag, "_zero"}, {31'b0, zero_o}, {31'b0, expZero});
    @(negedge clk);
    checkOutput({tag, "_drop"}, {30'b0, valid_o, ready_o}, 32'b01);
  endtask

  initial begin
    int lat, busyCycles, seenValid;
    rst_i   = 1'b0;
    valid_i = 1'b1;
    ctrl_i  = ALU_ADD;
    src_a_i = 32'd1;
    src_b_i = 32'd1;
    ready_i = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", {31'b0, valid_o}, 32'd0);
    checkOutput("rst_ready", {31'b0, ready_o}, 32'd1);
    checkOutput("rst_result", result_o, 32'd0);
    checkOutput("rst_zero", {31'b0, zero_o}, 32'd1);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
    rst_i   = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    checkOutput("rst_noaccept", {31'b0, valid_o}, 32'd0);

    runOp("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    runOp("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
    runOp("or", ALU_OR, 32'h1, 32'h2, 32'h3, 1'b0, 1);
    runOp("subz", ALU_SUB, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1);

    // Multiply with a stray request held high during the iteration.
    applyStimulus(ALU_MUL, 32'hFFFF_FFFF, 32'd3);
    checkOutput("mul_busy", {31'b0, busy_o}, 32'd1);
    checkOutput("mul_notready", {31'b0, ready_o}, 32'd0);
    valid_i = 1'b1;
    ctrl_i  = ALU_ADD;
    src_a_i = 32'd1;
    src_b_i = 32'd1;
    waitValid(lat, busyCycles);
    valid_i = 1'b0;
    checkOutput("mul_lat", 32'(lat), EARLY ? 32'd3 : 32'd33);
    checkOutput("mul_busycyc", 32'(busyCycles), EARLY ? 32'd2 : 32'd32);
    checkOutput("mul_res", result_o, 32'hFFFF_FFFD);
    @(negedge clk);
    checkOutput("mul_drop", {30'b0, valid_o, ready_o}, 32'b01);

    runOp("mul_mix", ALU_MUL, 32'h1234, 32'h5678, 32'h0626_0060, 1'b0, EARLY ? 16 : 33);

    // Backpressure: result must hold while downstream stalls.
    ready_i = 1'b0;
    applyStimulus(ALU_ADD, 32'h7FFF_FFFF, 32'd1);
    waitValid(lat, busyCycles);
    checkOutput("bp_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("bp_hold", result_o, 32'h8000_0000);
      checkOutput("bp_state", {29'b0, valid_o, ready_o, zero_o}, 32'b100);
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(negedge clk);
    checkOutput("bp_release", {30'b0, valid_o, ready_o}, 32'b01);

    runOp("ee_b1", ALU_MUL, 32'd9, 32'd1, 32'd9, 1'b0, EARLY ? 2 : 33);
    runOp("ee_b0", ALU_MUL, 32'd5, 32'd0, 32'd0, 1'b1, EARLY ? 1 : 33);
    runOp("ee_bmsb", ALU_MUL, 32'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, 33);

    // Reset after ten multiply iterations must abort without a result.
    applyStimulus(ALU_MUL, 32'd7, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    checkOutput("abort_inmul", {31'b0, busy_o}, 32'd1);
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    checkOutput("abort_state", {29'b0, valid_o, ready_o, busy_o}, 32'b010);
    checkOutput("abort_result", result_o, 32'd0);
    seenValid = 0;
    for (int i = 0; i < 40; i++) begin
      if (valid_o) seenValid++;
      @(negedge clk);
    end
    checkOutput("abort_novalid", 32'(seenValid), 32'd0);

    runOp("addi", ALU_ADDI, 32'd2, 32'd2, 32'd4, 1'b0, 1);
    runOp("ill111", 3'b111, 32'd5, 32'd6, 32'd0, 1'b1, 1);
    runOp("ill110", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
